// File: rtl/reg_1b_8sz_pkg.sv
// Shared constants, types and helpers for the 8-entry, 1-bit Fenwick XOR accumulator.
package reg_1b_8sz_pkg;

    localparam logic [1:0] OP_XOR   = 2'b00;
    localparam logic [1:0] OP_QUERY = 2'b01;

    localparam int N_ENTRIES = 8;
    localparam int IDX_W     = 3;
    localparam int NODE_W    = 4;

    typedef logic [N_ENTRIES-1:0] node_mask_t;
    typedef logic [IDX_W-1:0]     idx_t;
    typedef logic [NODE_W-1:0]    node_t;

    // Isolates the least-significant set bit of a 1-based node number.
    function automatic node_t lowbit(input node_t n);
        return n & (~n + node_t'(1));
    endfunction

endpackage

// File: rtl/reg_1b_8sz_if.sv
// Instruction bus of the Fenwick XOR accumulator: opcode, index, operand and query result.
interface reg_1b_8sz_if;
    import reg_1b_8sz_pkg::*;

    logic [1:0] inst;
    idx_t       idx;
    logic       in0;
    logic       out0;

    modport master (output inst, idx, in0, input out0);
    modport slave  (input inst, idx, in0, output out0);

endinterface

// File: rtl/reg_1b_8sz_fenwick_paths.sv
// Combinational Fenwick path decode: entry index -> nodes touched by an update and
// nodes combined by a prefix query. Bit k of each mask is node k+1.
module fenwick_paths
    import reg_1b_8sz_pkg::*;
(
    input  idx_t       idx,
    output node_mask_t umask,
    output node_mask_t qmask
);

    node_t n;
    assign n = {1'b0, idx} + node_t'(1);

    // Walking up from node 8 wraps the 4-bit node to 0, which ends the path.
    always_comb begin
        node_t u;
        umask = '0;
        u     = n;
        for (int s = 0; s < NODE_W; s++) begin
            if (u != '0) begin
                umask[u[IDX_W-1:0] - idx_t'(1)] = 1'b1;
                u = u + lowbit(u);
            end
        end
    end

    always_comb begin
        node_t q;
        qmask = '0;
        q     = n;
        for (int s = 0; s < NODE_W; s++) begin
            if (q != '0) begin
                qmask[q[IDX_W-1:0] - idx_t'(1)] = 1'b1;
                q = q - lowbit(q);
            end
        end
    end

endmodule

// File: rtl/reg_1b_8sz.sv
// 8-entry x 1-bit XOR accumulator stored as Fenwick nodes; one update or prefix query per cycle.
module reg_1b_8sz
    import reg_1b_8sz_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    reg_1b_8sz_if.slave   bus
);

    node_mask_t t;
    node_mask_t umask;
    node_mask_t qmask;
    logic       out_q;

    fenwick_paths u_paths (
        .idx   (bus.idx),
        .umask (umask),
        .qmask (qmask)
    );

    // in0 is only looked at on updates, so X on it elsewhere cannot reach the nodes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t     <= '0;
            out_q <= 1'b0;
        end else begin
            case (bus.inst)
                OP_XOR:   t     <= t ^ (umask & {N_ENTRIES{bus.in0}});
                OP_QUERY: out_q <= ^(t & qmask);
                default:  ;
            endcase
        end
    end

    assign bus.out0 = out_q;

endmodule

// File: tb/tb_reg_1b_8sz.sv
// Directed and random checks of reg_1b_8sz against a plain entry-array model.
module tb_reg_1b_8sz;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;
    logic arr [8];
    logic exp_out;

    reg_1b_8sz_if bus ();

    reg_1b_8sz dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [1:0] i, input logic [2:0] x, input logic v);
        bus.inst = i;
        bus.idx  = x;
        bus.in0  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [2:0] x, input logic v);
        cyc(2'b00, x, v);
    endtask

    task automatic qry(input logic [2:0] x);
        cyc(2'b01, x, 1'bx);
    endtask

    task automatic chk(input string tag, input logic expv);
        n_cmp++;
        assert (bus.out0 === expv)
        else begin
            n_fail++;
            $error("FAIL %s: out0 got %b expected %b", tag, bus.out0, expv);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2'b10, 3'd0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        cyc(2'b11, 3'd0, 1'b0);
        // update issued while in reset must be discarded
        upd(3'd0, 1'b1);
        chk("reset_out0", 1'b0);
        rst_n = 1'b1;
        qry(3'd7);  chk("reset_q7", 1'b0);
        qry(3'd0);  chk("reset_q0", 1'b0);

        // A = 1 0 0 0 1 0 0 0
        upd(3'd0, 1'b1); upd(3'd0, 1'b0); upd(3'd4, 1'b1);
        qry(3'd7);  chk("seq1_q7", 1'b0);
        qry(3'd3);  chk("seq1_q3", 1'b1);
        qry(3'd4);  chk("seq1_q4", 1'b0);

        // A = 0 0 0 0 1 1 1 0
        upd(3'd5, 1'b1); upd(3'd6, 1'b1); upd(3'd0, 1'b1);
        qry(3'd3);  chk("seq2_q3", 1'b0);
        qry(3'd7);  chk("seq2_q7", 1'b1);
        upd(3'd7, 1'b1);
        chk("upd_holds_out0", 1'b1);
        qry(3'd7);  chk("seq2_q7_after7", 1'b0);
        qry(3'd6);  chk("seq2_q6", 1'b1);

        // reset mid-sequence discards everything
        rst_n = 1'b0;
        qry(3'd7);
        chk("midreset_out0", 1'b0);
        rst_n = 1'b1;
        qry(3'd7);  chk("midreset_q7", 1'b0);
        qry(3'd5);  chk("midreset_q5", 1'b0);

        // read-after-write with no bubble
        upd(3'd2, 1'b1); qry(3'd2); chk("raw_set", 1'b1);
        upd(3'd2, 1'b1); qry(3'd2); chk("raw_clear", 1'b0);
        upd(3'd7, 1'b1); qry(3'd7); chk("raw_idx7", 1'b1);

        // walking one
        for (int k = 0; k < 8; k++) begin
            do_reset();
            upd(3'(k), 1'b1);
            for (int j = 0; j < 8; j++) begin
                qry(3'(j));
                chk($sformatf("walk_k%0d_q%0d", k, j), (j >= k) ? 1'b1 : 1'b0);
            end
        end

        // NOPs with toggling idx/in0 leave state and out0 alone
        do_reset();
        upd(3'd3, 1'b1);
        qry(3'd5);  chk("nop_pre", 1'b1);
        for (int c = 0; c < 8; c++) begin
            cyc((c % 2 == 0) ? 2'b10 : 2'b11, 3'(c * 3), 1'(c));
            chk($sformatf("nop_hold_%0d", c), 1'b1);
        end
        qry(3'd2);  chk("nop_q2", 1'b0);
        qry(3'd3);  chk("nop_q3", 1'b1);
        qry(3'd7);  chk("nop_q7", 1'b1);

        // random ops against an entry-array model
        do_reset();
        for (int j = 0; j < 8; j++) arr[j] = 1'b0;
        exp_out = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            logic [1:0] i;
            logic [2:0] x;
            logic       v;
            i = 2'($urandom_range(0, 3));
            x = 3'($urandom_range(0, 7));
            v = 1'($urandom_range(0, 1));
            if (i != 2'b00 && $urandom_range(0, 1) == 1) v = 1'bx;
            cyc(i, x, v);
            if (i == 2'b00) begin
                arr[x] = arr[x] ^ v;
            end else if (i == 2'b01) begin
                exp_out = 1'b0;
                for (int j = 0; j <= int'(x); j++) exp_out = exp_out ^ arr[j];
            end
            chk($sformatf("rand_%0d", c), exp_out);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_1b_8sz.md
# reg_1b_8sz

1-bit-wide, 8-entry XOR accumulator with prefix-XOR query, organised as a binary indexed (Fenwick) tree. Each cycle it executes one instruction: XOR a 1-bit value into one entry, or report the XOR of entries 0..idx inclusive. It is the storage and query core of the bitxor datapath. The logical array is never stored directly; only the 8 Fenwick node bits are held in flops.

## Interface
Parameters: none. Size is fixed at 8 entries × 1 bit; the constants live in the shared package.

Ports:
- clk — input, 1 — sole clock; all state changes on the rising edge.
- rst_n — input, 1 — reset, synchronous, active-low.
- inst — input, 2 — opcode:
  - 2'b00 = XOR-update.
  - 2'b01 = prefix query.
  - 2'b10 and 2'b11 = NOP.
- idx — input, 3 — entry index, 0..7.
- in0 — input, 1 — XOR operand for updates; ignored by all other opcodes.
- out0 — output, 1 — registered prefix-XOR result of the most recent query.

## Operation
- Logical model: array A[0..7] of 1-bit entries. The hardware stores Fenwick nodes T[1..8], where T[i] = XOR of A[i-lowbit(i) .. i-1] (1-based node, 0-based entry).
- Mapping: n = idx + 1, which is 4 bits wide (range 1..8).
- XOR-update (00): for n, n+lowbit(n), … while ≤ 8, T[node] ^= in0.
  - in0 = 0 is a legal no-op update.
  - Updating idx 7 touches only T[8].
- Prefix query (01): out0 ← XOR of T[n], T[n-lowbit(n)], … while > 0. This equals A[0] ^ … ^ A[idx].
  - idx 7 gives the XOR of all entries (T[8] alone).
  - idx 0 gives A[0] (T[1] alone).
- NOP (10/11): no state change; out0 holds.
- out0 holds its value through updates and NOPs. It changes only on a query or a reset.
- All path walks are evaluated combinationally within one cycle; there are at most 4 nodes per path.
- Inputs are sampled only at the clock edge. X on in0 during a query or NOP must not corrupt state.

## Timing
- Reset: while rst_n = 0 at a rising edge, all T ← 0 and out0 ← 0. Reset has priority over any opcode in the same cycle.
- A reset arriving mid-sequence discards all prior updates.
- Update latency: 1 cycle. Node bits change at the edge that samples inst = 00.
- Query latency: 1 cycle. out0 is valid after the edge that samples inst = 01 and stays stable until the next query.
- A query reflects every update sampled on earlier edges; read-after-write needs no bubble.
- Back-to-back operations at full rate, one instruction per cycle. No handshake and no stall.
- There is no wrap-around: idx is 3 bits, so every index is legal.

## Structure
- Shared package contents:
  - Opcode localparams OP_XOR = 2'b00, OP_QUERY = 2'b01.
  - N_ENTRIES = 8, IDX_W = 3, NODE_W = 4.
  - A lowbit function.
- Sub-module fenwick_paths: purely combinational. It maps idx to an 8-bit update-mask (nodes touched by an update) and an 8-bit query-mask (nodes summed by a query).
- Top level:
  - Node register T[8:1] with update T ← T ^ (mask & {8{in0}}) when inst = 00.
  - out0 ← ^(T & qmask) when inst = 01.

## Test plan
- Reset, then query idx 7 → out0 = 0. Assert rst_n = 0 after the updates below → next query at idx 7 returns 0.
- Updates (0,1), (0,0), (4,1), then query 7 → 0, query 3 → 1, query 4 → 0. Each result appears 1 cycle after its query.
- Continue with updates (5,1), (6,1), (0,1), then query 3 → 0, query 7 → 1. This checks that the earlier state is retained.
- Query immediately after an update to the same idx, with no gap → the result includes the new value.
- Walking one: update idx k with 1, query all 0..7 → out0 = 1 exactly for indices ≥ k. Repeat for k = 0..7, resetting between runs.
- inst = 10/11 with toggling idx/in0 → node state unchanged; out0 holds its last query value. Randomized ops compared against a plain A[] array model for 1000 cycles.
